// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register feeding the register-file write port.
// Non-loads retire one cycle after capture. Loads issue a DRAM read and
// stall the MEM stage until read data returns or the wait counter reaches
// TIMEOUT, in which case the load retires with zero data and flags an error.
// Also keeps a retired-instruction counter and sticky trace error flags.
//
//   state | meaning
//   IDLE  | accepting MEM instructions; non-loads retire on the next edge
//   WAIT  | load issued to DRAM; waiting for dram_rvalid or timeout
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        rf_clk,
  input  logic        rf_rst,
  input  logic        mem_valid,
  input  logic        mem_is_load,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_pc4,
  input  logic [31:0] mem_alu_c,
  input  logic [31:0] mem_sext2,
  input  logic [2:0]  mem_wD_sel,
  input  logic        mem_wb_ena,
  input  logic        dram_rvalid,
  input  logic [31:0] dram_rdata,
  output logic        dram_req,
  output logic [31:0] dram_addr,
  output logic        stall_mem,
  output logic [31:0] inst_WB,
  output logic [31:0] pc4,
  output logic [31:0] alu_c,
  output logic [31:0] sext2,
  output logic [31:0] rdo,
  output logic [2:0]  wD_sel,
  output logic        wb_ena,
  output logic        wb_valid,
  output logic [31:0] commit_cnt,
  output logic        err_timeout,
  output logic        err_spurious
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0] WCNT_MAX = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  wcnt;

  // load payload held while the DRAM read is outstanding
  logic [31:0] h_inst;
  logic [31:0] h_pc4;
  logic [31:0] h_alu_c;
  logic [31:0] h_sext2;
  logic [2:0]  h_wD_sel;
  logic        h_wb_ena;

  // hold upstream while a load is being issued or is still waiting on data
  assign stall_mem = ((state == IDLE) & mem_valid & mem_is_load) |
                     ((state == WAIT) & ~dram_rvalid & (wcnt != WCNT_MAX));

  // pipeline register, load sequencing FSM, commit counter and error flags
  always_ff @(posedge rf_clk or posedge rf_rst) begin
    if (rf_rst) begin
      state        <= IDLE;
      wcnt         <= '0;
      dram_req     <= 1'b0;
      dram_addr    <= '0;
      inst_WB      <= '0;
      pc4          <= '0;
      alu_c        <= '0;
      sext2        <= '0;
      rdo          <= '0;
      wD_sel       <= '0;
      wb_ena       <= 1'b0;
      wb_valid     <= 1'b0;
      commit_cnt   <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      h_inst       <= '0;
      h_pc4        <= '0;
      h_alu_c      <= '0;
      h_sext2      <= '0;
      h_wD_sel     <= '0;
      h_wb_ena     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dram_rvalid) err_spurious <= 1'b1;
          if (mem_valid && !mem_is_load) begin
            inst_WB    <= mem_inst;
            pc4        <= mem_pc4;
            alu_c      <= mem_alu_c;
            sext2      <= mem_sext2;
            wD_sel     <= mem_wD_sel;
            rdo        <= '0;
            wb_ena     <= mem_wb_ena;
            wb_valid   <= 1'b1;
            commit_cnt <= commit_cnt + 32'd1;
          end else if (mem_valid) begin
            h_inst    <= mem_inst;
            h_pc4     <= mem_pc4;
            h_alu_c   <= mem_alu_c;
            h_sext2   <= mem_sext2;
            h_wD_sel  <= mem_wD_sel;
            h_wb_ena  <= mem_wb_ena;
            dram_req  <= 1'b1;
            dram_addr <= mem_alu_c;
            wcnt      <= '0;
            wb_ena    <= 1'b0;
            wb_valid  <= 1'b0;
            state     <= WAIT;
          end else begin
            wb_ena   <= 1'b0;
            wb_valid <= 1'b0;
          end
        end
        WAIT: begin
          // data arriving on the timeout cycle wins over the timeout
          if (dram_rvalid || (wcnt == WCNT_MAX)) begin
            inst_WB    <= h_inst;
            pc4        <= h_pc4;
            alu_c      <= h_alu_c;
            sext2      <= h_sext2;
            wD_sel     <= h_wD_sel;
            rdo        <= dram_rvalid ? dram_rdata : 32'd0;
            wb_ena     <= h_wb_ena;
            wb_valid   <= 1'b1;
            commit_cnt <= commit_cnt + 32'd1;
            dram_req   <= 1'b0;
            if (!dram_rvalid) err_timeout <= 1'b1;
            state      <= IDLE;
          end else begin
            wcnt     <= wcnt + 8'd1;
            wb_ena   <= 1'b0;
            wb_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed table, multi-cycle corner
// sequences, then randomized traffic against a transaction-level model.
module tb_mem_wb_stage;

  localparam int TMO = 4;

  logic        rf_clk, rf_rst;
  logic        mem_valid, mem_is_load;
  logic [31:0] mem_inst, mem_pc4, mem_alu_c, mem_sext2;
  logic [2:0]  mem_wD_sel;
  logic        mem_wb_ena;
  logic        dram_rvalid;
  logic [31:0] dram_rdata;
  logic        dram_req;
  logic [31:0] dram_addr;
  logic        stall_mem;
  logic [31:0] inst_WB, pc4, alu_c, sext2, rdo;
  logic [2:0]  wD_sel;
  logic        wb_ena, wb_valid;
  logic [31:0] commit_cnt;
  logic        err_timeout, err_spurious;

  int n_chk = 0;
  int n_err = 0;

  mem_wb_stage #(.TIMEOUT(TMO)) dut (
    .rf_clk(rf_clk), .rf_rst(rf_rst),
    .mem_valid(mem_valid), .mem_is_load(mem_is_load),
    .mem_inst(mem_inst), .mem_pc4(mem_pc4), .mem_alu_c(mem_alu_c),
    .mem_sext2(mem_sext2), .mem_wD_sel(mem_wD_sel), .mem_wb_ena(mem_wb_ena),
    .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
    .dram_req(dram_req), .dram_addr(dram_addr), .stall_mem(stall_mem),
    .inst_WB(inst_WB), .pc4(pc4), .alu_c(alu_c), .sext2(sext2), .rdo(rdo),
    .wD_sel(wD_sel), .wb_ena(wb_ena), .wb_valid(wb_valid),
    .commit_cnt(commit_cnt), .err_timeout(err_timeout),
    .err_spurious(err_spurious)
  );

  initial rf_clk = 1'b0;
  always #5 rf_clk = ~rf_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic ld, input logic rv,
                       input logic [31:0] alu, input logic [31:0] rdata);
    mem_valid   = v;
    mem_is_load = ld;
    mem_alu_c   = alu;
    dram_rvalid = rv;
    dram_rdata  = rdata;
  endtask

  task automatic step();
    @(posedge rf_clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        v, ld, rv;
    logic [31:0] alu, rdata;
    logic        e_stall;
    logic [31:0] e_alu, e_rdo;
    logic        e_ena, e_valid, e_req;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[10];

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] inst, pc4, alu, sext;
    logic [2:0]  wd;
    logic        ena;
  } payload_t;

  payload_t    m_wb, m_held;
  logic [31:0] m_rdo, m_cnt, m_addr;
  logic        m_valid, m_et, m_es, m_req;
  bit          m_busy;
  int          m_waited;

  task automatic model_reset();
    m_wb = '0; m_held = '0; m_rdo = '0; m_cnt = '0; m_addr = '0;
    m_valid = 0; m_et = 0; m_es = 0; m_req = 0; m_busy = 0; m_waited = 0;
  endtask

  task automatic retire(input payload_t p, input logic [31:0] data);
    m_wb = p; m_rdo = data; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
  endtask

  task automatic bubble();
    m_wb.ena = 1'b0; m_valid = 1'b0;
  endtask

  function automatic logic model_stall(input logic v, input logic ld, input logic rv);
    if (m_busy) return !rv && (m_waited < TMO);
    return v && ld;
  endfunction

  task automatic model_edge(input logic v, input logic ld, input logic rv,
                            input payload_t p, input logic [31:0] rdata);
    if (!m_busy) begin
      if (rv) m_es = 1'b1;
      if (v && !ld) retire(p, 32'd0);
      else if (v) begin
        m_held = p; m_busy = 1; m_waited = 0; m_req = 1'b1; m_addr = p.alu;
        bubble();
      end else bubble();
    end else if (rv) begin
      retire(m_held, rdata); m_busy = 0; m_req = 1'b0;
    end else if (m_waited == TMO) begin
      retire(m_held, 32'd0); m_et = 1'b1; m_busy = 0; m_req = 1'b0;
    end else begin
      m_waited++; bubble();
    end
  endtask

  initial begin
    logic [258:0] act_v, exp_v;
    payload_t p;

    rf_rst = 1'b1;
    drive(0, 0, 0, 32'd0, 32'd0);
    mem_inst = 32'h0000_0013; mem_pc4 = 32'd4; mem_sext2 = 32'd0;
    mem_wD_sel = 3'd1; mem_wb_ena = 1'b1;

    vecs[0] = '{1,0,0, 32'h12345678, 0, 0, 32'h12345678, 0,           1,1,0, 1};
    vecs[1] = '{1,1,0, 32'h100,      0, 1, 32'h12345678, 0,           0,0,1, 1};
    vecs[2] = '{1,1,0, 32'h100,      0, 1, 32'h12345678, 0,           0,0,1, 1};
    vecs[3] = '{1,1,0, 32'h100,      0, 1, 32'h12345678, 0,           0,0,1, 1};
    vecs[4] = '{1,1,0, 32'h100,      0, 1, 32'h12345678, 0,           0,0,1, 1};
    vecs[5] = '{1,1,1, 32'h100, 32'hCAFEBABE, 0, 32'h100, 32'hCAFEBABE, 1,1,0, 2};
    vecs[6] = '{1,1,0, 32'h200,      0, 1, 32'h100, 32'hCAFEBABE,     0,0,1, 2};
    vecs[7] = '{1,1,1, 32'h200, 32'h11112222, 0, 32'h200, 32'h11112222, 1,1,0, 3};
    vecs[8] = '{1,0,0, 32'hAAAA5555, 0, 0, 32'hAAAA5555, 0,           1,1,0, 4};
    vecs[9] = '{0,0,0, 32'h0,        0, 0, 32'hAAAA5555, 0,           0,0,0, 4};

    step(); step();
    chk("rst_req", {31'd0, dram_req}, 32'd0);
    chk("rst_addr", dram_addr, 32'd0);
    chk("rst_alu", alu_c, 32'd0);
    chk("rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_cnt", commit_cnt, 32'd0);
    chk("rst_errs", {30'd0, err_timeout, err_spurious}, 32'd0);
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    rf_rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].ld, vecs[i].rv, vecs[i].alu, vecs[i].rdata);
      #1;
      chk($sformatf("tbl%0d_stall", i), {31'd0, stall_mem}, {31'd0, vecs[i].e_stall});
      step();
      chk($sformatf("tbl%0d_alu", i), alu_c, vecs[i].e_alu);
      chk($sformatf("tbl%0d_rdo", i), rdo, vecs[i].e_rdo);
      chk($sformatf("tbl%0d_ctl", i), {29'd0, wb_ena, wb_valid, dram_req},
          {29'd0, vecs[i].e_ena, vecs[i].e_valid, vecs[i].e_req});
      chk($sformatf("tbl%0d_cnt", i), commit_cnt, vecs[i].e_cnt);
      if (vecs[i].e_req) chk($sformatf("tbl%0d_addr", i), dram_addr, vecs[i].alu);
    end

    // rvalid on the exact timeout cycle: data wins, no timeout error
    drive(1, 1, 0, 32'h500, 32'd0);
    step();
    for (int i = 0; i < TMO; i++) begin
      #1 chk($sformatf("rvto_stall%0d", i), {31'd0, stall_mem}, 32'd1);
      step();
    end
    #1 chk("rvto_stall_last", {31'd0, stall_mem}, 32'd0);
    drive(1, 1, 1, 32'h500, 32'h5A5A0001);
    step();
    chk("rvto_rdo", rdo, 32'h5A5A0001);
    chk("rvto_err", {31'd0, err_timeout}, 32'd0);
    chk("rvto_valid", {30'd0, wb_valid, dram_req}, 32'd2);
    chk("rvto_cnt", commit_cnt, 32'd5);

    // timeout with no rvalid, then a normal load keeps the sticky flag
    drive(1, 1, 0, 32'h600, 32'd0);
    step();
    for (int i = 0; i < TMO; i++) begin
      chk($sformatf("to_wait%0d", i), {30'd0, wb_valid, dram_req}, 32'd1);
      step();
    end
    #1 chk("to_stall", {31'd0, stall_mem}, 32'd0);
    step();
    chk("to_rdo", rdo, 32'd0);
    chk("to_alu", alu_c, 32'h600);
    chk("to_err", {31'd0, err_timeout}, 32'd1);
    chk("to_valid", {30'd0, wb_valid, dram_req}, 32'd2);
    chk("to_cnt", commit_cnt, 32'd6);
    drive(1, 1, 0, 32'h700, 32'd0);
    step();
    drive(1, 1, 1, 32'h700, 32'h77);
    step();
    chk("sticky_rdo", rdo, 32'h77);
    chk("sticky_err", {31'd0, err_timeout}, 32'd1);
    chk("sticky_cnt", commit_cnt, 32'd7);

    // asynchronous reset on the second WAIT cycle
    drive(1, 1, 0, 32'h800, 32'd0);
    step();
    step();
    #2 rf_rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, dram_req}, 32'd0);
    chk("arst_ena", {30'd0, wb_ena, wb_valid}, 32'd0);
    chk("arst_cnt", commit_cnt, 32'd0);
    chk("arst_err", {31'd0, err_timeout}, 32'd0);
    drive(0, 0, 0, 32'd0, 32'd0);
    #1 chk("arst_idle", {31'd0, stall_mem}, 32'd0);
    #1 rf_rst = 1'b0;

    // spurious rvalid in IDLE
    drive(0, 0, 1, 32'd0, 32'hDEADBEEF);
    step();
    chk("spur_ena", {30'd0, wb_ena, wb_valid}, 32'd0);
    chk("spur_err", {31'd0, err_spurious}, 32'd1);
    chk("spur_cnt", commit_cnt, 32'd0);
    drive(0, 0, 0, 32'd0, 32'd0);

    // randomized traffic against the model
    rf_rst = 1'b1;
    #3 rf_rst = 1'b0;
    model_reset();
    step();
    for (int c = 0; c < 1500; c++) begin
      logic v, ld, rv;
      logic [31:0] rd;
      v  = ($urandom_range(0, 3) != 0);
      ld = $urandom_range(0, 1) == 1;
      rv = ($urandom_range(0, 3) == 0);
      rd = $urandom;
      p.inst = $urandom; p.pc4 = $urandom; p.alu = $urandom; p.sext = $urandom;
      p.wd = 3'($urandom_range(0, 7)); p.ena = $urandom_range(0, 1) == 1;
      mem_inst = p.inst; mem_pc4 = p.pc4; mem_sext2 = p.sext;
      mem_wD_sel = p.wd; mem_wb_ena = p.ena;
      drive(v, ld, rv, p.alu, rd);
      #1 chk($sformatf("rnd%0d_stall", c), {31'd0, stall_mem},
             {31'd0, model_stall(v, ld, rv)});
      step();
      model_edge(v, ld, rv, p, rd);
      act_v = {inst_WB, pc4, alu_c, sext2, wD_sel, wb_ena, rdo, wb_valid,
               commit_cnt, err_timeout, err_spurious, dram_req, dram_addr};
      exp_v = {m_wb.inst, m_wb.pc4, m_wb.alu, m_wb.sext, m_wb.wd, m_wb.ena,
               m_rdo, m_valid, m_cnt, m_et, m_es, m_req, m_addr};
      n_chk++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL rnd%0d_outs: got %h expected %h", c, act_v, exp_v);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
